// File: rtl/mem_req_sched.sv
// Shares one memory request/response port between instruction fetch and the LSU.
// An owner FIFO routes in-order responses back to the requester; flushed fetch responses are dropped.
module mem_req_sched #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [31:0] if_req_addr_i,
  output logic        if_resp_valid_o,
  input  logic        if_resp_ready_i,
  output logic [31:0] if_resp_data_o,
  input  logic        ls_req_valid_i,
  output logic        ls_req_ready_o,
  input  logic [31:0] ls_req_addr_i,
  input  logic [31:0] ls_req_wdata_i,
  input  logic [3:0]  ls_req_wstrb_i,
  input  logic        ls_req_we_i,
  output logic        ls_resp_valid_o,
  input  logic        ls_resp_ready_i,
  output logic [31:0] ls_resp_data_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  output logic [31:0] mem_req_wdata_o,
  output logic [3:0]  mem_req_wstrb_o,
  output logic        mem_req_we_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_resp_data_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] owner_if_q, owner_if_d;
  logic [MAX_OUTSTANDING-1:0] discard_q, discard_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SW-1:0]              starve_q, starve_d;

  logic full_s, empty_s, if_elig_s, ls_elig_s, grant_if_s, grant_ls_s;
  logic push_s, pop_s, if_fire_s, ls_fire_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    ptr_inc = (ptr == LAST_PTR) ? {PW{1'b0}} : ptr + PW'(1);
  endfunction

  // Arbitration and request mux; every handshake is held off while in reset.
  always_comb begin
    full_s     = (cnt_q == FULL_CNT);
    empty_s    = (cnt_q == {CW{1'b0}});
    if_elig_s  = if_req_valid_i && !flush;
    ls_elig_s  = ls_req_valid_i;
    grant_if_s = rst && !full_s && if_elig_s && (!ls_elig_s || (starve_q == STARVE_MAX));
    grant_ls_s = rst && !full_s && ls_elig_s && !grant_if_s;
    mem_req_valid_o = grant_if_s || grant_ls_s;
    if_req_ready_o  = grant_if_s && mem_req_ready_i;
    ls_req_ready_o  = grant_ls_s && mem_req_ready_i;
    if (grant_if_s) begin
      mem_req_addr_o  = if_req_addr_i;
      mem_req_wdata_o = 32'h0000_0000;
      mem_req_wstrb_o = 4'b0000;
      mem_req_we_o    = 1'b0;
    end else begin
      mem_req_addr_o  = ls_req_addr_i;
      mem_req_wdata_o = ls_req_wdata_i;
      mem_req_wstrb_o = ls_req_wstrb_i;
      mem_req_we_o    = ls_req_we_i;
    end
    push_s    = mem_req_valid_o && mem_req_ready_i;
    if_fire_s = push_s && grant_if_s;
    ls_fire_s = push_s && grant_ls_s;
  end

  // Response routing from the FIFO head; discarded fetch responses are consumed silently.
  always_comb begin
    if_resp_valid_o  = 1'b0;
    ls_resp_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    if_resp_data_o   = mem_resp_data_i;
    ls_resp_data_o   = mem_resp_data_i;
    if (rst && !empty_s) begin
      if (!owner_if_q[rd_ptr_q]) begin
        ls_resp_valid_o  = mem_resp_valid_i;
        mem_resp_ready_o = ls_resp_ready_i;
      end else if (discard_q[rd_ptr_q] || flush) begin
        mem_resp_ready_o = 1'b1;
      end else begin
        if_resp_valid_o  = mem_resp_valid_i;
        mem_resp_ready_o = if_resp_ready_i;
      end
    end else begin
      mem_resp_ready_o = 1'b0;
    end
    pop_s = mem_resp_valid_i && mem_resp_ready_o;
  end

  // Owner FIFO next state; flush tags every fetch entry, including the one being popped.
  always_comb begin
    owner_if_d = owner_if_q;
    discard_d  = discard_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (push_s && (PW'(i) == wr_ptr_q)) begin
        owner_if_d[i] = grant_if_s;
        discard_d[i]  = 1'b0;
      end else if (flush && owner_if_q[i]) begin
        discard_d[i] = 1'b1;
      end else begin
        discard_d[i] = discard_q[i];
      end
    end
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_s) - CW'(pop_s);
  end

  // Fetch starvation counter.
  always_comb begin
    if (if_fire_s || !if_req_valid_i) begin
      starve_d = {SW{1'b0}};
    end else if (ls_fire_s && if_elig_s && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_if_q <= {MAX_OUTSTANDING{1'b0}};
      discard_q  <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      starve_q   <= {SW{1'b0}};
    end else begin
      owner_if_q <= owner_if_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed bench for mem_req_sched (MAX_OUTSTANDING=2, STARVE_LIMIT=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_req_sched;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
  logic [31:0] if_req_addr, if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_resp_valid, ls_resp_ready;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_resp_data;
  logic [3:0]  ls_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_wstrb;
  logic [9:0]  exp_if;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mem_req_sched #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req_valid_i(if_req_valid), .if_req_ready_o(if_req_ready), .if_req_addr_i(if_req_addr),
    .if_resp_valid_o(if_resp_valid), .if_resp_ready_i(if_resp_ready), .if_resp_data_o(if_resp_data),
    .ls_req_valid_i(ls_req_valid), .ls_req_ready_o(ls_req_ready), .ls_req_addr_i(ls_req_addr),
    .ls_req_wdata_i(ls_req_wdata), .ls_req_wstrb_i(ls_req_wstrb), .ls_req_we_i(ls_req_we),
    .ls_resp_valid_o(ls_resp_valid), .ls_resp_ready_i(ls_resp_ready), .ls_resp_data_o(ls_resp_data),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
    .mem_req_wdata_o(mem_req_wdata), .mem_req_wstrb_o(mem_req_wstrb), .mem_req_we_o(mem_req_we),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready), .mem_resp_data_i(mem_resp_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    flush = 1'b0;
    if_req_valid = 1'b0; if_req_addr = 32'h0;
    ls_req_valid = 1'b0; ls_req_addr = 32'h0; ls_req_wdata = 32'h0; ls_req_wstrb = 4'h0; ls_req_we = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
  endtask

  initial begin
    exp_if = 10'b10_0001_0000;
    rst = 1'b0;
    idle();
    #1;
    check_eq("rst_mem_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_if_req_ready", if_req_ready, 1'b0);
    check_eq("rst_ls_req_ready", ls_req_ready, 1'b0);
    check_eq("rst_mem_resp_ready", mem_resp_ready, 1'b0);
    check_eq("rst_if_resp_valid", if_resp_valid, 1'b0);
    check_eq("rst_ls_resp_valid", ls_resp_valid, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Single LS read
    @(negedge clk); ls_req_valid = 1'b1; ls_req_addr = 32'h100; #1;
    check_eq("ls_rd_valid", mem_req_valid, 1'b1);
    check_eq("ls_rd_addr", mem_req_addr, 32'h100);
    check_eq("ls_rd_we", mem_req_we, 1'b0);
    check_eq("ls_rd_ready", ls_req_ready, 1'b1);
    @(negedge clk); idle(); #1;
    check_eq("ls_rd_idle", mem_req_valid, 1'b0);
    @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF; #1;
    check_eq("ls_rd_resp_valid", ls_resp_valid, 1'b1);
    check_eq("ls_rd_resp_data", ls_resp_data, 32'hDEADBEEF);
    check_eq("ls_rd_if_resp", if_resp_valid, 1'b0);
    check_eq("ls_rd_mem_ready", mem_resp_ready, 1'b1);

    // Contention: LS x4, IF, LS x4, IF
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 32'h1000 + 32'(i * 4);
      ls_req_valid = 1'b1; ls_req_addr = 32'h2000 + 32'(i * 4);
      mem_resp_valid = (i > 0); mem_resp_data = 32'hA000 + 32'(i);
      #1;
      check_eq($sformatf("arb_if_ready_%0d", i), if_req_ready, exp_if[i]);
      check_eq($sformatf("arb_addr_%0d", i), mem_req_addr,
               exp_if[i] ? 32'h1000 + 32'(i * 4) : 32'h2000 + 32'(i * 4));
    end
    @(negedge clk); idle(); mem_resp_valid = 1'b1; mem_resp_data = 32'h55; #1;
    check_eq("arb_tail_if_valid", if_resp_valid, 1'b1);
    check_eq("arb_tail_if_data", if_resp_data, 32'h55);
    check_eq("arb_tail_ls_valid", ls_resp_valid, 1'b0);

    // Full boundary
    @(negedge clk); idle(); ls_req_valid = 1'b1; ls_req_addr = 32'h300; #1;
    check_eq("full_push0", ls_req_ready, 1'b1);
    @(negedge clk); ls_req_addr = 32'h304; #1;
    check_eq("full_push1", ls_req_ready, 1'b1);
    @(negedge clk); ls_req_addr = 32'h308; #1;
    check_eq("full_ready", ls_req_ready, 1'b0);
    check_eq("full_valid", mem_req_valid, 1'b0);
    @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = 32'h3000; #1;
    check_eq("full_pop_resp", ls_resp_valid, 1'b1);
    check_eq("full_pop_ready", ls_req_ready, 1'b0);
    check_eq("full_pop_valid", mem_req_valid, 1'b0);
    @(negedge clk); mem_resp_valid = 1'b0; #1;
    check_eq("full_after_ready", ls_req_ready, 1'b1);
    check_eq("full_after_addr", mem_req_addr, 32'h308);
    @(negedge clk); ls_req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h3004; #1;
    check_eq("full_drain0", ls_resp_data, 32'h3004);
    @(negedge clk); mem_resp_data = 32'h3008; #1;
    check_eq("full_drain1", ls_resp_valid, 1'b1);
    @(negedge clk); #1;
    check_eq("empty_resp_ready", mem_resp_ready, 1'b0);
    check_eq("empty_ls_valid", ls_resp_valid, 1'b0);

    // Flush drop: IF 0x0 and LS 0x4 outstanding, then flush
    @(negedge clk); idle(); if_req_valid = 1'b1; if_req_addr = 32'h0; #1;
    check_eq("fl_if_push", if_req_ready, 1'b1);
    @(negedge clk); idle(); ls_req_valid = 1'b1; ls_req_addr = 32'h4; #1;
    check_eq("fl_ls_push", ls_req_ready, 1'b1);
    @(negedge clk); idle(); flush = 1'b1; #1;
    check_eq("fl_full", mem_req_valid, 1'b0);
    @(negedge clk); idle(); mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA0000; #1;
    check_eq("fl_A_if_valid", if_resp_valid, 1'b0);
    check_eq("fl_A_ready", mem_resp_ready, 1'b1);
    check_eq("fl_A_ls_valid", ls_resp_valid, 1'b0);
    @(negedge clk); mem_resp_data = 32'hBBBB0000; #1;
    check_eq("fl_B_ls_valid", ls_resp_valid, 1'b1);
    check_eq("fl_B_ls_data", ls_resp_data, 32'hBBBB0000);
    check_eq("fl_B_if_valid", if_resp_valid, 1'b0);
    @(negedge clk); mem_resp_data = 32'hCCCC0000; #1;
    check_eq("fl_end_empty", mem_resp_ready, 1'b0);

    // Flush with the fetch response at the head
    @(negedge clk); idle(); if_req_valid = 1'b1; if_req_addr = 32'h10; #1;
    check_eq("flh_push", if_req_ready, 1'b1);
    @(negedge clk); if_req_addr = 32'h14; flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h1234; #1;
    check_eq("flh_if_resp", if_resp_valid, 1'b0);
    check_eq("flh_consume", mem_resp_ready, 1'b1);
    check_eq("flh_if_ready", if_req_ready, 1'b0);
    check_eq("flh_mem_valid", mem_req_valid, 1'b0);
    @(negedge clk); idle(); mem_resp_valid = 1'b1; #1;
    check_eq("flh_empty", mem_resp_ready, 1'b0);

    // Async reset with two entries outstanding (starve count at 2 beforehand)
    @(negedge clk); idle(); if_req_valid = 1'b1; if_req_addr = 32'h700; ls_req_valid = 1'b1; ls_req_addr = 32'h600;
    @(negedge clk); ls_req_addr = 32'h604; #1;
    check_eq("rr_push1", ls_req_ready, 1'b1);
    @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = 32'h66; #1;
    check_eq("rr_pre_ls_valid", ls_resp_valid, 1'b1);
    check_eq("rr_pre_full", mem_req_valid, 1'b0);
    #1 rst = 1'b0;
    #1;
    check_eq("rr_ls_valid", ls_resp_valid, 1'b0);
    check_eq("rr_resp_ready", mem_resp_ready, 1'b0);
    check_eq("rr_mem_valid", mem_req_valid, 1'b0);
    check_eq("rr_ls_ready", ls_req_ready, 1'b0);
    check_eq("rr_if_ready", if_req_ready, 1'b0);
    check_eq("rr_if_valid", if_resp_valid, 1'b0);
    @(negedge clk); rst = 1'b1; #1;
    check_eq("rr_post_empty", mem_resp_ready, 1'b0);
    check_eq("rr_post_ls_ready", ls_req_ready, 1'b1);
    check_eq("rr_post_if_ready", if_req_ready, 1'b0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); mem_resp_valid = 1'b1; #1;
      check_eq($sformatf("rr_starve_%0d", i), if_req_ready, (i == 4) ? 1'b1 : 1'b0);
    end
    @(negedge clk); idle(); mem_resp_valid = 1'b1; mem_resp_data = 32'h77; #1;
    check_eq("rr_tail_if", if_resp_data, 32'h77);
    @(negedge clk); idle();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
